// File: rtl/core_pkg.sv
// Shared definitions for the output-SRAM drain path: FSM states, lane geometry
// and the SRAM control encodings used on the shared read port.
package core_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        LOAD = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } drain_state_t;

    localparam int LANES         = 8;
    localparam int LANE_BW       = 16;
    localparam int BEATS_PER_ROW = 4;

    localparam logic CEN_ON   = 1'b0;
    localparam logic CEN_OFF  = 1'b1;
    localparam logic WEN_READ = 1'b1;

endpackage

// File: rtl/psum_relu.sv
// Combinational per-lane ReLU on a full SRAM row: a signed 16-bit lane that is
// negative becomes zero when en is set; everything else passes untouched.
module psum_relu
    import core_pkg::*;
#(
    parameter int P_DATA_BW = 128
) (
    input  logic                 en,
    input  logic [P_DATA_BW-1:0] data_in,
    output logic [P_DATA_BW-1:0] data_out
);

    localparam int N_LANES = P_DATA_BW / LANE_BW;

    function automatic logic signed [LANE_BW-1:0] relu_lane(
        input logic signed [LANE_BW-1:0] lane,
        input logic                      clamp_en
    );
        if (clamp_en && (lane < 0))
            return '0;
        return lane;
    endfunction

    always_comb begin
        data_out = '0;
        for (int i = 0; i < N_LANES; i++) begin
            data_out[i*LANE_BW +: LANE_BW] = relu_lane(data_in[i*LANE_BW +: LANE_BW], en);
        end
    end

endmodule

// File: rtl/o_sram_drain.sv
// Drains every output SRAM row after op_done, optionally clamps negative lanes,
// and streams each row as four 32-bit valid/ready beats (beat 0 = bits [31:0]).
module o_sram_drain
    import core_pkg::*;
#(
    parameter int P_ROWS    = 16,
    parameter int P_ADDR_BW = 4,
    parameter int P_DATA_BW = 128,
    parameter int P_OUT_BW  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 relu_en,
    output logic                 busy,
    output logic                 done,
    input  logic [P_DATA_BW-1:0] O_Q,
    output logic [P_ADDR_BW-1:0] O_ADDR,
    output logic                 O_CEN,
    output logic                 O_WEN,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [P_OUT_BW-1:0]  m_data,
    output logic                 m_last
);

    localparam logic [1:0]           LAST_BEAT = 2'(BEATS_PER_ROW - 1);
    localparam logic [P_ADDR_BW-1:0] LAST_ROW  = P_ADDR_BW'(P_ROWS - 1);

    drain_state_t         state;
    drain_state_t         state_nxt;
    logic [P_ADDR_BW-1:0] row_cnt;
    logic [1:0]           beat_cnt;
    logic                 relu_lat;
    logic [P_DATA_BW-1:0] row_buf;
    logic [P_DATA_BW-1:0] row_clamped;
    logic                 hs;
    logic                 last_row;
    logic                 last_beat;

    psum_relu #(
        .P_DATA_BW (P_DATA_BW)
    ) u_relu (
        .en       (relu_lat),
        .data_in  (O_Q),
        .data_out (row_clamped)
    );

    assign hs        = (state == SEND) && m_ready;
    assign last_row  = (row_cnt == LAST_ROW);
    assign last_beat = (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (hs && last_beat) state_nxt = last_row ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters advance only on handshakes; relu_en is frozen for the whole pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt  <= '0;
            beat_cnt <= '0;
            relu_lat <= 1'b0;
            row_buf  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        relu_lat <= relu_en;
                        row_cnt  <= '0;
                        beat_cnt <= '0;
                    end
                end
                LOAD: row_buf <= row_clamped;
                SEND: begin
                    if (hs) begin
                        beat_cnt <= beat_cnt + 2'd1;
                        if (last_beat && !last_row)
                            row_cnt <= row_cnt + P_ADDR_BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Stream outputs derive from registered state only, so m_ready never reaches m_valid.
    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        O_CEN   = (state == READ) ? CEN_ON : CEN_OFF;
        O_WEN   = WEN_READ;
        O_ADDR  = row_cnt;
        m_valid = (state == SEND);
        m_data  = '0;
        if (m_valid)
            m_data = row_buf[32'(beat_cnt) * P_OUT_BW +: P_OUT_BW];
        m_last  = m_valid && last_row && last_beat;
    end

endmodule
